aes_block_uart_tx: RTL and testbench
====================================

Name: aes_block_uart_tx

Overview:
Serializes one 128-bit AES result block into 16 consecutive 8N1 UART frames on a single tx line. It is the transmit-side counterpart of the loopback's 16-byte receive/assemble path, and sits between the AES core output (valid pulse plus 128-bit ciphertext) and the board TX pin. It contains its own baud-timed bit engine and a byte sequencer with a valid/ready block handshake.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, UART line rate.
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (truncated, 868 at defaults), clock cycles per bit. Legal range is 2 or more; the bench may override it directly.
GAP_BITS, 0, idle (mark) bit-times inserted between bytes of one block, never after the last byte.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
block_in  in  128  block to transmit; byte 0 = block_in[127:120], byte 15 = block_in[7:0]
block_valid  in  1  block_in is valid
block_ready  out  1  block can be accepted; transfer occurs when valid and ready are both high on a clk edge
tx  out  1  UART serial output, idle high
busy  out  1  a block is in flight
done  out  1  one-cycle pulse when the last stop bit of byte 15 completes

Behaviour:
- Reset (rst_n=0 sampled on clk edge): tx=1, block_ready=1, busy=0, done=0, all counters 0, state IDLE. Reset mid-frame aborts the transfer: tx=1 from the next edge and the partial block is discarded.
- Handshake: in IDLE, block_ready=1. On valid&&ready, block_in is latched into a 128-bit shift register and the byte index is set to 0. block_ready and busy go 0/1 on the next edge. block_valid is ignored whenever block_ready=0, and block_in may change freely after acceptance.
- Bit engine states and tx level:
  - START: tx=0.
  - DATA: tx=current byte bit, LSB first, bit index 0..7.
  - STOP: tx=1.
  - GAP: tx=1, lasts GAP_BITS bit-times; skipped when GAP_BITS=0.
- Each bit lasts exactly CLKS_PER_BIT cycles. The baud counter has width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, and advances on wrap.
- Timing: the start bit of byte 0 drives tx low on the edge after acceptance, i.e. latency 1 cycle. With GAP_BITS=0 the byte frames are contiguous: the next START follows STOP with no extra cycle.
- Sequencing: STOP(byte<15) -> GAP or START of byte+1, with the shift register advancing by 8 bits. STOP(byte 15) -> IDLE.
- On the STOP->IDLE edge: done=1 for exactly one cycle, busy=0, block_ready=1. A block_valid present in that same cycle is accepted, giving back-to-back blocks with the next start bit one cycle later.
- Total cycles per block from acceptance to done: 16*(10+GAP_BITS)*CLKS_PER_BIT - GAP_BITS*CLKS_PER_BIT + 1. At defaults this is 138 881.
- There is no internal queueing. Upstream must hold block_valid until it sees block_ready, or use its own buffer.

Decomposition:
- Package aes_uart_pkg:
  - BLOCK_BYTES=16
  - BLOCK_W=128
  - function clks_per_bit(clk_freq, baud)
  - typedef enum tx_state_t {IDLE, START, DATA, STOP, GAP}
  - These items are shared with the receive path.
- One sub-module, uart_tx_byte: a single-byte 8N1 serializer with a start/byte input, a busy output and a frame_done pulse, parameterized by CLKS_PER_BIT.
- The top holds the block register, the byte counter, the gap timer and the handshake.

Test Plan:
1. Reset: hold rst_n=0 for 10 cycles -> tx=1, block_ready=1, busy=0, done=0. rst_n high with block_valid=0 -> tx stays 1 for 1000 cycles.
2. Single block 69c4e0d86a7b0430d8cdb78070b4c55a, defaults -> bench UART decoder receives 69,c4,e0,...,5a in order with every stop bit=1. tx falls 1 cycle after the handshake. Each bit is 868 cycles. done pulses once, 138 881 cycles after acceptance.
3. Back-to-back with CLKS_PER_BIT=4: present 0x1112...20, then hold valid with 0xffee...00 -> second block accepted in the done cycle and its start bit follows 1 cycle later. 32 bytes decoded correctly.
4. Valid while busy: change block_in and pulse block_valid mid-transfer -> ignored, original bytes sent, exactly 16 frames.
5. Reset mid-byte: assert rst_n=0 during DATA bit 3 of byte 5 -> tx=1 next edge, block_ready=1. A new block afterwards starts again from byte 0.
6. GAP_BITS=2, CLKS_PER_BIT=4 -> exactly 8 idle-high cycles between consecutive stop bit and start bit, none after byte 15.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared constants, bit-engine state type and baud helper for the AES UART
// transmit and receive paths.
package aes_uart_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = 128;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/aes_block_uart_tx_if.sv
// Block handshake between the AES core output and the UART block serializer.
interface aes_block_uart_tx_if;
    import aes_uart_pkg::*;

    logic [BLOCK_W-1:0] block_in;
    logic               block_valid;
    logic               block_ready;

    modport master (output block_in, output block_valid, input block_ready);
    modport slave  (input block_in, input block_valid, output block_ready);

endinterface

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A start seen in the last stop-bit cycle chains
// the next frame with no idle cycle in between.
module uart_tx_byte
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic             tx_q;
    logic             bit_end;

    assign bit_end = (baud_cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            baud_cnt_q <= (state_q == IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= START;
                        shreg_q <= data;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            tx_q      <= shreg_q[1];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (start) begin
                            state_q <= START;
                            shreg_q <= data;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == STOP) && bit_end;

endmodule

// File: rtl/aes_block_uart_tx.sv
// Serializes a 128-bit AES block as 16 UART frames, byte 0 = block_in[127:120],
// with optional idle gap between bytes and a valid/ready block handshake.
module aes_block_uart_tx
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int unsigned GAP_BITS     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_block_uart_tx_if.slave  blk,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    localparam int unsigned GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam int unsigned IDX_W      = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BLOCK_BYTES - 1);
    localparam bit NO_GAP = (GAP_BITS == 0);

    typedef enum logic [1:0] {SeqIdle, SeqLaunch, SeqSend, SeqGap} seq_state_t;

    seq_state_t         seq_q;
    logic [BLOCK_W-1:0] block_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic accept;
    logic last_byte;
    logic byte_start;
    logic byte_busy;
    logic frame_done;

    assign accept    = blk.block_valid && ready_q;
    assign last_byte = (byte_idx_q == LAST_BYTE);

    // The engine latches block_q's top byte on byte_start; block_q shifts on the same edge.
    assign byte_start = (seq_q == SeqLaunch && !byte_busy)
                     || (seq_q == SeqSend && frame_done && !last_byte && NO_GAP)
                     || (seq_q == SeqGap && gap_cnt_q == GAP_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_q      <= SeqIdle;
            block_q    <= '0;
            byte_idx_q <= '0;
            gap_cnt_q  <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (byte_start) begin
                block_q <= block_q << 8;
            end
            unique case (seq_q)
                SeqIdle: begin
                    if (accept) begin
                        block_q    <= blk.block_in;
                        byte_idx_q <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        seq_q      <= SeqLaunch;
                    end
                end
                SeqLaunch: begin
                    if (byte_start) begin
                        seq_q <= SeqSend;
                    end
                end
                SeqSend: begin
                    if (frame_done) begin
                        if (last_byte) begin
                            seq_q   <= SeqIdle;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            if (!NO_GAP) begin
                                seq_q     <= SeqGap;
                                gap_cnt_q <= '0;
                            end
                        end
                    end
                end
                SeqGap: begin
                    if (byte_start) begin
                        seq_q <= SeqSend;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (byte_start),
        .data       (block_q[BLOCK_W-1 -: 8]),
        .tx         (tx),
        .busy       (byte_busy),
        .frame_done (frame_done)
    );

    assign blk.block_ready = ready_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Self-checking bench: records every tx sample, then decodes frames against the
// expected byte order, bit timing, gap spacing and done timing.
module tb_aes_block_uart_tx;
    import aes_uart_pkg::*;

    localparam int CA = 6;
    localparam int GA = 0;
    localparam int CB = 4;
    localparam int GB = 2;
    localparam int WAIT_LIMIT = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;

    aes_block_uart_tx_if if_a ();
    aes_block_uart_tx_if if_b ();

    aes_block_uart_tx #(.CLKS_PER_BIT(CA), .GAP_BITS(GA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .blk   (if_a),
        .tx    (tx_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    aes_block_uart_tx #(.CLKS_PER_BIT(CB), .GAP_BITS(GB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .blk   (if_b),
        .tx    (tx_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic hist_a[$];
    logic hist_b[$];
    int   done_at_a[$];
    int   done_at_b[$];

    // hist[i] is the tx level after the i-th rising edge since time zero.
    always @(negedge clk) begin
        hist_a.push_back(tx_a);
        hist_b.push_back(tx_b);
        if (done_a === 1'b1) done_at_a.push_back(hist_a.size() - 1);
        if (done_b === 1'b1) done_at_b.push_back(hist_b.size() - 1);
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic tx_at(input bit sel, input int i);
        if (i < 0) return 1'bx;
        if (sel) return (i < hist_b.size()) ? hist_b[i] : 1'bx;
        return (i < hist_a.size()) ? hist_a[i] : 1'bx;
    endfunction

    function automatic int block_cycles(input int c, input int g);
        return 16 * (10 + g) * c - g * c + 1;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_blocks(input bit sel, input logic [127:0] blks[$], output int acc[$]);
        acc = {};
        foreach (blks[i]) begin
            int guard;
            guard = 0;
            if (sel) begin
                if_b.block_in = blks[i];
                if_b.block_valid = 1'b1;
            end else begin
                if_a.block_in = blks[i];
                if_a.block_valid = 1'b1;
            end
            while (!(sel ? if_b.block_ready : if_a.block_ready) && guard < WAIT_LIMIT) begin
                step();
                guard++;
            end
            check_eq("ready_wait", guard < WAIT_LIMIT, 1'b1);
            acc.push_back(sel ? hist_b.size() : hist_a.size());
            step();
        end
        if (sel) if_b.block_valid = 1'b0;
        else if_a.block_valid = 1'b0;
    endtask

    task automatic verify(input bit sel, input string tag, input logic [127:0] blks[$],
                          input int acc[$], input int c, input int g);
        int dq[$];
        int s, hi_end, bad, e;
        logic [7:0] d;
        logic [2:0] frm;
        logic [127:0] cur;
        dq = sel ? done_at_b : done_at_a;
        foreach (blks[i]) begin
            cur = blks[i];
            for (int k = 0; k < 16; k++) begin
                s = acc[i] + 1 + k * (10 + g) * c;
                frm = {tx_at(sel, s - 1), tx_at(sel, s), tx_at(sel, s + c - 1)};
                for (int b = 0; b < 8; b++) d[b] = tx_at(sel, s + (1 + b) * c + c / 2);
                hi_end = (k == 15) ? s + 10 * c : s + (10 + g) * c;
                bad = 0;
                for (int j = s + 9 * c; j < hi_end; j++) if (tx_at(sel, j) !== 1'b1) bad++;
                check_eq({tag, "_frame"}, frm, 3'b100);
                check_eq({tag, "_byte"}, d, cur[127 - 8 * k -: 8]);
                check_eq({tag, "_stop_gap"}, bad, 0);
            end
        end
        check_eq({tag, "_done_count"}, dq.size(), blks.size());
        foreach (acc[i]) begin
            if (i < dq.size()) check_eq({tag, "_done_at"}, dq[i], acc[i] + block_cycles(c, g));
        end
        e = acc[acc.size() - 1] + block_cycles(c, g);
        bad = 0;
        for (int j = e; j < e + g * c + 4; j++) if (tx_at(sel, j) !== 1'b1) bad++;
        check_eq({tag, "_idle_after"}, bad, 0);
        if (sel) done_at_b = {};
        else done_at_a = {};
    endtask

    initial begin
        logic [127:0] blks[$];
        int acc[$];
        int base, bad, target, guard;

        if_a.block_in = '0;
        if_a.block_valid = 1'b0;
        if_b.block_in = '0;
        if_b.block_valid = 1'b0;
        rst_n = 1'b0;
        step(10);
        check_eq("rst_tx_a", tx_a, 1'b1);
        check_eq("rst_ready_a", if_a.block_ready, 1'b1);
        check_eq("rst_busy_a", busy_a, 1'b0);
        check_eq("rst_done_a", done_a, 1'b0);
        check_eq("rst_tx_b", tx_b, 1'b1);
        check_eq("rst_ready_b", if_b.block_ready, 1'b1);

        rst_n = 1'b1;
        base = hist_a.size();
        step(1000);
        bad = 0;
        for (int j = base; j < hist_a.size(); j++) if (hist_a[j] !== 1'b1 || hist_b[j] !== 1'b1) bad++;
        check_eq("idle_tx", bad, 0);
        check_eq("idle_no_done", done_at_a.size() + done_at_b.size(), 0);

        blks = {};
        blks.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        send_blocks(0, blks, acc);
        step(block_cycles(CA, GA) + 20);
        verify(0, "single", blks, acc, CA, GA);

        blks = {};
        blks.push_back(128'h1112131415161718191a1b1c1d1e1f20);
        blks.push_back(128'hffeeddccbbaa99887766554433221100);
        send_blocks(0, blks, acc);
        check_eq("b2b_accept", acc[1] - acc[0], block_cycles(CA, GA) + 1);
        step(block_cycles(CA, GA) + 20);
        verify(0, "b2b", blks, acc, CA, GA);

        blks = {};
        for (int i = 0; i < 3; i++) blks.push_back(rand_block());
        send_blocks(0, blks, acc);
        step(block_cycles(CA, GA) + 20);
        verify(0, "rand", blks, acc, CA, GA);

        blks = {};
        blks.push_back(rand_block());
        send_blocks(0, blks, acc);
        step(300);
        if_a.block_in = rand_block();
        if_a.block_valid = 1'b1;
        check_eq("busy_ready", if_a.block_ready, 1'b0);
        check_eq("busy_flag", busy_a, 1'b1);
        step();
        if_a.block_valid = 1'b0;
        step(block_cycles(CA, GA) + 20);
        verify(0, "ignore", blks, acc, CA, GA);

        blks = {};
        blks.push_back(rand_block());
        send_blocks(0, blks, acc);
        target = acc[0] + 1 + 5 * 10 * CA + 4 * CA;
        guard = 0;
        while (hist_a.size() <= target + 1 && guard < WAIT_LIMIT) begin
            step();
            guard++;
        end
        check_eq("mid_wait", guard < WAIT_LIMIT, 1'b1);
        rst_n = 1'b0;
        step();
        check_eq("mid_rst_tx", tx_a, 1'b1);
        check_eq("mid_rst_ready", if_a.block_ready, 1'b1);
        check_eq("mid_rst_busy", busy_a, 1'b0);
        step(5);
        rst_n = 1'b1;
        step(5);
        check_eq("mid_rst_no_done", done_at_a.size(), 0);
        done_at_a = {};
        done_at_b = {};
        blks = {};
        blks.push_back(rand_block());
        send_blocks(0, blks, acc);
        step(block_cycles(CA, GA) + 20);
        verify(0, "after_rst", blks, acc, CA, GA);

        blks = {};
        blks.push_back(rand_block());
        blks.push_back(rand_block());
        send_blocks(1, blks, acc);
        check_eq("gap_b2b_accept", acc[1] - acc[0], block_cycles(CB, GB) + 1);
        step(block_cycles(CB, GB) + 20);
        verify(1, "gap", blks, acc, CB, GB);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
